keypad_event_fsm: RTL and testbench
===================================

KEYPAD_EVENT_FSM -- requirements
Module: keypad_event_fsm

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: clock cycles each row is driven before the scan advances (legal range >= 3).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required to accept a press or a release (legal range >= 2).
REQ-003 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port col, input, 4: keypad column lines, already synchronized upstream, active-low (0 = key in driven row pressed).
REQ-006 Port row, output, 4: keypad row drive, one-cold active-low, registered.
REQ-007 Port key_code, output, 4: hex value of the accepted key, registered, held until the next accepted press.
REQ-008 Port key_valid, output, 1: one-cycle pulse marking a newly accepted press.
REQ-009 Port key_held, output, 1: level, high from the accepted press until the debounced release.

Function
REQ-010 The FSM SHALL have exactly four states: SCAN, DB_PRESS, HELD, DB_RELEASE.
REQ-011 In SCAN, row SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap), one step every SCAN_CYCLES cycles.
REQ-012 In SCAN, col SHALL be sampled only when the dwell counter equals SCAN_CYCLES-1, covering synchronizer latency.
REQ-013 A sample with exactly one col bit low SHALL latch row index and col pattern, freeze row, clear the debounce counter and enter DB_PRESS.
REQ-014 A sample with zero or two-plus col bits low SHALL be ignored and scanning SHALL continue.
REQ-015 In DB_PRESS, each cycle col equals the latched pattern SHALL increment the counter; any mismatch SHALL return to SCAN, resuming at the next row with no output change.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with a match, the FSM SHALL enter HELD, update key_code, and assert key_valid for exactly the following cycle.
REQ-017 key_code, key_valid and key_held SHALL change on the same clock edge (key_valid lags the last matching col sample by one cycle).
REQ-018 The key map SHALL be (row0..3 x col0..3): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-019 In HELD, row SHALL stay frozen, keys in other columns SHALL be ignored, and a high latched column bit SHALL clear the counter and enter DB_RELEASE.
REQ-020 In DB_RELEASE, the latched column low again SHALL return to HELD with no new key_valid pulse (bounce, not a new press).
REQ-021 In DB_RELEASE, DEBOUNCE_CYCLES consecutive high cycles on the latched column SHALL deassert key_held and enter SCAN at the next row.
REQ-022 Holding a key SHALL produce exactly one key_valid pulse regardless of hold duration; no auto-repeat.
REQ-023 Counters SHALL be sized $clog2 of their parameter and SHALL saturate, never wrap, within a state.

Reset
REQ-024 Reset SHALL set state SCAN, row 1110, both counters 0, key_code 0, key_valid 0, key_held 0.
REQ-025 Reset asserted in any state, including mid-debounce or HELD, SHALL take effect on the next edge and override all other transitions; a held key SHALL then be re-accepted as a new press only after full debounce.

Structure
REQ-026 A shared package keypad_pkg SHALL hold the state enum, the 16-entry key map constant, and the row count (4).
REQ-027 One sub-module, keypad_decode (combinational: row index + one-hot col -> 4-bit code), SHALL be instantiated; the FSM, scan counter and debounce counter SHALL stay in keypad_event_fsm.

Verification (DEBOUNCE_CYCLES=8, SCAN_CYCLES=4)
REQ-028 Clean press at row1/col2 (col=1011) held 50 cycles, then released -> one key_valid pulse, key_code=6, key_held high until 8 cycles after release.
REQ-029 Bouncing press, col toggling every 3 cycles for 20 cycles then stable -> no pulse during bounce; exactly one pulse, 8 cycles into the stable interval.
REQ-030 Two columns low in the same row (col=1100) -> no key_valid, scan keeps rotating with 4-cycle dwell.
REQ-031 Row3/col1 held, second key pressed in col3, first released -> key_code=0 only, one pulse; second key accepted only after debounced release and rescan.
REQ-032 Release glitch (latched column high 3 cycles, then low) in HELD -> key_held stays high, no second pulse.
REQ-033 Reset asserted during DB_PRESS at count 5 -> all outputs at reset values next cycle, row=1110, no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, row count and hex key map for the keypad scanner
package keypad_pkg;
  localparam int ROWS = 4;
  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} state_t;
  // Indexed by {row, col}: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };
endpackage

// File: rtl/keypad_decode.sv
// keypad_decode: row index plus one-hot column to hex key code
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [$clog2(ROWS)-1:0] row_idx,
  input  logic [3:0]              col_hot,
  output logic [3:0]              code
);
  logic [1:0] col_idx;
  always_comb begin
    col_idx = {col_hot[3] | col_hot[2], col_hot[3] | col_hot[1]};
    code = KEY_MAP[{row_idx, col_idx}];
  end
endmodule

// File: rtl/keypad_event_fsm.sv
// keypad_event_fsm: row-scanning keypad reader with press/release debounce and one-shot key events
module keypad_event_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(ROWS);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  state_t state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] row_idx;
  logic [3:0] col_lat, code, pressed;
  logic one_low, lat_high, col_match, advance;
  always_comb begin
    pressed = ~col;
    one_low = pressed != 4'd0 && (pressed & (pressed - 4'd1)) == 4'd0;
    lat_high = |(col & ~col_lat);
    col_match = col == col_lat;
    // Every way back into SCAN resumes at the following row with a fresh dwell
    advance = (state == SCAN && scan_cnt == SCAN_MAX && !one_low) ||
              (state == DB_PRESS && !col_match) ||
              (state == DB_RELEASE && lat_high && db_cnt == DB_MAX);
  end
  keypad_decode u_decode (
    .row_idx(row_idx),
    .col_hot(~col_lat),
    .code   (code)
  );
  always_ff @(posedge clk) begin
    key_valid <= 1'b0;
    if (reset) begin
      state    <= SCAN;
      row      <= 4'b1110;
      row_idx  <= '0;
      scan_cnt <= '0;
      db_cnt   <= '0;
      col_lat  <= 4'hF;
      key_code <= '0;
      key_held <= 1'b0;
    end else begin
      if (advance) begin
        row      <= {row[2:0], row[3]};
        row_idx  <= row_idx + RW'(1);
        scan_cnt <= '0;
      end
      case (state)
        SCAN: begin
          if (scan_cnt != SCAN_MAX) scan_cnt <= scan_cnt + SW'(1);
          else if (one_low) begin
            col_lat <= col;
            db_cnt  <= '0;
            state   <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (!col_match) state <= SCAN;
          else if (db_cnt != DB_MAX) db_cnt <= db_cnt + DW'(1);
          else begin
            state     <= HELD;
            key_code  <= code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end
        end
        HELD: begin
          if (lat_high) begin
            db_cnt <= '0;
            state  <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (!lat_high) state <= HELD;
          else if (db_cnt != DB_MAX) db_cnt <= db_cnt + DW'(1);
          else begin
            state    <= SCAN;
            key_held <= 1'b0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_event_fsm.sv
// tb_keypad_event_fsm: keypad matrix emulation with a procedural scanner model feeding a pulse scoreboard
module tb_keypad_event_fsm;
  localparam int S = 4;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] col, row, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  string kmap = "123A456B789CE0FD";
  int tests = 0, fails = 0, n_exp = 0, n_seen = 0, m_conf = -1;
  logic [3:0] exp_row = 4'b1110, exp_code = 4'h0;
  logic exp_held = 1'b0;
  logic [3:0] exp_q[$];
  bit ab;

  keypad_event_fsm #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rowpat(int r);
    logic [3:0] v;
    v = 4'b1110;
    for (int i = 0; i < r; i++) v = {v[2:0], v[3]};
    return v;
  endfunction

  function automatic logic [3:0] colpat(int r);
    logic [15:0] s;
    s = keys >> (4 * r);
    return ~s[3:0];
  endfunction

  function automatic logic [3:0] kcode(int i);
    byte ch;
    ch = kmap[i];
    return (ch >= "A") ? 4'(ch - 8'd55) : 4'(ch - 8'd48);
  endfunction

  // The physical matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) if (row == rowpat(r)) col = colpat(r);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ab = reset;
  endtask

  // Scanner behaviour as a sequential program: dwell, sample, confirm, hold, confirm release
  task automatic model_body();
    int r = 0, n, c;
    logic [3:0] p, q;
    forever begin
      exp_row = rowpat(r);
      repeat (S) begin tick(); if (ab) return; end
      p = colpat(r);
      if ($countones(~p) != 1) begin r = (r + 1) % 4; continue; end
      c = !p[0] ? 0 : !p[1] ? 1 : !p[2] ? 2 : 3;
      n = 0;
      m_conf = 0;
      while (n < D) begin
        tick(); if (ab) return;
        if (colpat(r) != p) break;
        n++;
        m_conf = n;
      end
      m_conf = -1;
      if (n < D) begin r = (r + 1) % 4; continue; end
      exp_code = kcode(r * 4 + c);
      exp_held = 1'b1;
      exp_q.push_back(exp_code);
      n_exp++;
      // One edge notices the column go high, then D more consecutive high edges release it
      n = 0;
      while (n < D + 1) begin
        tick(); if (ab) return;
        q = colpat(r) >> c;
        n = q[0] ? n + 1 : 0;
      end
      exp_held = 1'b0;
      r = (r + 1) % 4;
    end
  endtask

  initial forever begin
    exp_row = 4'b1110;
    exp_held = 1'b0;
    exp_code = 4'h0;
    m_conf = -1;
    exp_q.delete();
    wait (!reset);
    model_body();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("row", {28'b0, row}, {28'b0, exp_row});
      check("key_held", {31'b0, key_held}, {31'b0, exp_held});
      check("key_code", {28'b0, key_code}, {28'b0, exp_code});
      if (key_valid) begin
        n_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got key_valid=1 code %0h expected no pulse at %0t", key_code, $time);
        end else check("pulse_code", {28'b0, key_code}, {28'b0, exp_q.pop_front()});
      end else if (exp_q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL missing_pulse: got key_valid=0 expected pulse code %0h at %0t", exp_q.pop_front(), $time);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t, k, nb;
    idle(3);
    check("rst_row", {28'b0, row}, 32'hE);
    check("rst_code", {28'b0, key_code}, 32'h0);
    check("rst_valid", {31'b0, key_valid}, 32'h0);
    check("rst_held", {31'b0, key_held}, 32'h0);
    reset = 1'b0;
    idle(10);
    keys[6] = 1'b1; idle(60); keys[6] = 1'b0; idle(40);
    for (int i = 0; i < 7; i++) begin keys[5] = ~keys[5]; idle(3); end
    keys[5] = 1'b1; idle(60); keys[5] = 1'b0; idle(40);
    keys[0] = 1'b1; keys[1] = 1'b1; idle(40); keys[0] = 1'b0; keys[1] = 1'b0; idle(20);
    keys[13] = 1'b1; idle(60); keys[15] = 1'b1; idle(20); keys[13] = 1'b0; idle(60);
    keys[15] = 1'b0; idle(40);
    keys[10] = 1'b1; idle(50); keys[10] = 1'b0; idle(3); keys[10] = 1'b1; idle(30);
    keys[10] = 1'b0; idle(40);
    keys[3] = 1'b1;
    t = 0;
    while (m_conf != 5 && t < 200) begin idle(1); t++; end
    check("conf_reach", {31'b0, m_conf == 5}, 32'h1);
    reset = 1'b1;
    idle(1);
    check("mid_rst_row", {28'b0, row}, 32'hE);
    check("mid_rst_valid", {31'b0, key_valid}, 32'h0);
    check("mid_rst_held", {31'b0, key_held}, 32'h0);
    check("mid_rst_code", {28'b0, key_code}, 32'h0);
    reset = 1'b0;
    idle(60); keys[3] = 1'b0; idle(40);
    repeat (25) begin
      k = $urandom_range(15);
      keys[k] = 1'b1;
      if ($urandom_range(3) == 0) keys[$urandom_range(15)] = 1'b1;
      if ($urandom_range(1) == 1) begin
        nb = $urandom_range(6);
        for (int i = 0; i < nb; i++) begin keys[k] = ~keys[k]; idle($urandom_range(1, 4)); end
      end
      keys[k] = 1'b1;
      idle($urandom_range(5, 80));
      keys = '0;
      idle($urandom_range(5, 40));
    end
    idle(60);
    check("pulse_count", n_seen, n_exp);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
